// File: rtl/booth_pp_accumulator.sv
// Booth partial-product accumulator: 3-stage adder tree reducing eight
// partial products to one product, followed by a signed dot-product accumulator.
module booth_pp_accumulator #(
  parameter int WIDTH_DATA = 16,
  parameter int NUM_PP     = 8,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_last,
  input  logic [WIDTH_DATA*2*NUM_PP-1:0] pp,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ACC_WIDTH-1:0]           out_data,
  output logic                           out_ovf,
  output logic                           busy
);

  localparam int PW = 2 * WIDTH_DATA;

  logic                 stall;
  logic                 accept;

  logic [3:0][PW-1:0]   s1_d, s1_q;
  logic                 v1_d, v1_q;
  logic                 l1_d, l1_q;

  logic [1:0][PW-1:0]   s2_d, s2_q;
  logic                 v2_d, v2_q;
  logic                 l2_d, l2_q;

  logic [PW-1:0]        p3_d, p3_q;
  logic                 v3_d, v3_q;
  logic                 l3_d, l3_q;

  logic [ACC_WIDTH-1:0] acc_d, acc_q;
  logic                 sticky_d, sticky_q;
  logic                 open_d, open_q;

  logic                 ov_d, ov_q;
  logic [ACC_WIDTH-1:0] od_d, od_q;
  logic                 oo_d, oo_q;

  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0] sum;
  logic                 ovf_new;

  // A held result blocks the whole pipeline, so nothing in flight is lost.
  always_comb begin
    stall  = ov_q & ~out_ready;
    accept = in_valid & ~stall;
  end

  // Stage 1: pairwise sums of the eight partial products.
  always_comb begin
    s1_d = '0;
    for (int i = 0; i < 4; i++) begin
      s1_d[i] = pp[(2*i)*PW +: PW] + pp[(2*i+1)*PW +: PW];
    end
    v1_d = accept;
    l1_d = accept & in_last;
  end

  // Stage 1 register, frozen while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
      v1_q <= 1'b0;
      l1_q <= 1'b0;
    end else if (!stall) begin
      s1_q <= s1_d;
      v1_q <= v1_d;
      l1_q <= l1_d;
    end
  end

  // Stage 2: reduce four sums to two.
  always_comb begin
    s2_d    = '0;
    s2_d[0] = s1_q[0] + s1_q[1];
    s2_d[1] = s1_q[2] + s1_q[3];
    v2_d    = v1_q;
    l2_d    = l1_q;
  end

  // Stage 2 register, frozen while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_q <= '0;
      v2_q <= 1'b0;
      l2_q <= 1'b0;
    end else if (!stall) begin
      s2_q <= s2_d;
      v2_q <= v2_d;
      l2_q <= l2_d;
    end
  end

  // Stage 3: final product, exact within the modular product width.
  always_comb begin
    p3_d = s2_q[0] + s2_q[1];
    v3_d = v2_q;
    l3_d = l2_q;
  end

  // Stage 3 register, frozen while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p3_q <= '0;
      v3_q <= 1'b0;
      l3_q <= 1'b0;
    end else if (!stall) begin
      p3_q <= p3_d;
      v3_q <= v3_d;
      l3_q <= l3_d;
    end
  end

  // Sign-extended add with signed overflow detection on the wrapped sum.
  always_comb begin
    prod_ext = ACC_WIDTH'($signed(p3_q));
    sum      = acc_q + prod_ext;
    ovf_new  = (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &
               (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
  end

  // Accumulate, and on a last beat publish the result and restart the sum.
  always_comb begin
    acc_d    = acc_q;
    sticky_d = sticky_q;
    open_d   = open_q;
    ov_d     = ov_q;
    od_d     = od_q;
    oo_d     = oo_q;
    if (!stall) begin
      ov_d = 1'b0;
      if (v3_q) begin
        if (l3_q) begin
          ov_d     = 1'b1;
          od_d     = sum;
          oo_d     = sticky_q | ovf_new;
          acc_d    = '0;
          sticky_d = 1'b0;
          open_d   = 1'b0;
        end else begin
          acc_d    = sum;
          sticky_d = sticky_q | ovf_new;
          open_d   = 1'b1;
        end
      end
    end
  end

  // Accumulator and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      sticky_q <= 1'b0;
      open_q   <= 1'b0;
      ov_q     <= 1'b0;
      od_q     <= '0;
      oo_q     <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      open_q   <= open_d;
      ov_q     <= ov_d;
      od_q     <= od_d;
      oo_q     <= oo_d;
    end
  end

  // Open partial sums count as busy even when the pipeline is empty.
  always_comb begin
    in_ready  = ~stall;
    out_valid = ov_q;
    out_data  = od_q;
    out_ovf   = oo_q;
    busy      = v1_q | v2_q | v3_q | open_q | sticky_q | (|acc_q);
  end

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Directed self-checking bench for booth_pp_accumulator.
// Products are split randomly across the eight pp slices.
module tb_booth_pp_accumulator;

  localparam int WD = 16;
  localparam int AW = 40;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [255:0]  pp;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic          out_ovf;
  logic          busy;

  int checks;
  int errors;
  int cyc;
  int stall_waits;

  logic [AW-1:0] qd[$];
  logic          qo[$];
  int            qc[$];

  booth_pp_accumulator #(
    .WIDTH_DATA(WD),
    .NUM_PP(8),
    .ACC_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_last(in_last),
    .pp(pp),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_ovf(out_ovf),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    #1;
    if (rst_n && out_valid && out_ready) begin
      qd.push_back(out_data);
      qo.push_back(out_ovf);
      qc.push_back(cyc);
    end
  end

  function automatic logic [255:0] split(input logic [31:0] p);
    logic [255:0] v;
    logic [31:0]  s;
    logic [31:0]  r;
    v = '0;
    s = '0;
    for (int i = 1; i < 8; i++) begin
      r = $urandom;
      v[i*32 +: 32] = r;
      s = s + r;
    end
    v[31:0] = p - s;
    return v;
  endfunction

  task automatic clear_q();
    qd.delete();
    qo.delete();
    qc.delete();
  endtask

  task automatic beat(input logic [31:0] prod, input logic last);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_last  = last;
    pp       = split(prod);
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
      stall_waits++;
    end
    if (n >= 100) begin
      errors++;
      $display("FAIL beat_accept timeout in_ready=%0b required 1", in_ready);
    end
  endtask

  task automatic idle_drive();
    in_valid = 1'b0;
    in_last  = $urandom_range(0, 1);
    pp       = {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic idle();
    @(negedge clk);
    idle_drive();
  endtask

  task automatic wait_results(input int n);
    int k;
    k = 0;
    while (qd.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (qd.size() < n) begin
      errors++;
      $display("FAIL wait_results got %0d required %0d", qd.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    out_ready = 1'b1;
    idle_drive();
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_out vld=%0b ovf=%0b required 0 0", out_valid, out_ovf);
    end
    checks++;
    if (out_data !== 40'h0) begin
      errors++;
      $display("FAIL reset_data got %h required 0", out_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release rdy=%0b busy=%0b required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_single();
    logic ev;
    clear_q();
    beat(32'hFFFFFFF1, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) idle_drive();
      ev = (k == 4);
      checks++;
      if (out_valid !== ev) begin
        errors++;
        $display("FAIL single_latency k=%0d got %0b required %0b", k, out_valid, ev);
      end
      if (k == 4) begin
        checks++;
        if (out_data !== 40'hFFFFFFFFF1 || out_ovf !== 1'b0) begin
          errors++;
          $display("FAIL single_data got %h/%0b required fffffffff1/0", out_data, out_ovf);
        end
      end
      if (k == 5) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL single_busy got %0b required 0", busy);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    stall_waits = 0;
    beat(32'd100, 1'b0);
    beat(-32'sd20, 1'b0);
    beat(32'd7, 1'b0);
    beat(-32'sd87, 1'b1);
    beat(32'd5, 1'b0);
    beat(32'd6, 1'b1);
    idle();
    wait_results(2);
    checks++;
    if (stall_waits != 0) begin
      errors++;
      $display("FAIL b2b_in_ready waits=%0d required 0", stall_waits);
    end
    if (qd.size() >= 2) begin
      checks++;
      if (qd[0] !== 40'h0 || qo[0] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_first got %h/%0b required 0/0", qd[0], qo[0]);
      end
      checks++;
      if (qd[1] !== 40'd11 || qo[1] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_second got %h/%0b required b/0", qd[1], qo[1]);
      end
      checks++;
      if (qc[1] - qc[0] != 2) begin
        errors++;
        $display("FAIL b2b_gap got %0d required 2", qc[1] - qc[0]);
      end
    end
  endtask

  task automatic test_stall();
    int k;
    clear_q();
    @(negedge clk);
    out_ready = 1'b0;
    beat(32'd11, 1'b1);
    beat(32'd22, 1'b1);
    idle();
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_wait out_valid=%0b required 1", out_valid);
    end
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 40'd11) begin
        errors++;
        $display("FAIL stall_hold i=%0d rdy=%0b vld=%0b data=%h required 0 1 b",
                 i, in_ready, out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    wait_results(2);
    repeat (5) @(negedge clk);
    checks++;
    if (qd.size() != 2) begin
      errors++;
      $display("FAIL stall_count got %0d required 2", qd.size());
    end
    if (qd.size() >= 2) begin
      checks++;
      if (qd[0] !== 40'd11 || qd[1] !== 40'd22) begin
        errors++;
        $display("FAIL stall_order got %h %h required b 16", qd[0], qd[1]);
      end
    end
  endtask

  task automatic test_overflow();
    clear_q();
    for (int i = 0; i < 512; i++) begin
      beat(32'h40000000, (i == 511));
    end
    idle();
    wait_results(1);
    if (qd.size() >= 1) begin
      checks++;
      if (qd[0] !== 40'h8000000000 || qo[0] !== 1'b1) begin
        errors++;
        $display("FAIL ovf_result got %h/%0b required 8000000000/1", qd[0], qo[0]);
      end
    end
    clear_q();
    beat(32'd1, 1'b1);
    idle();
    wait_results(1);
    if (qd.size() >= 1) begin
      checks++;
      if (qd[0] !== 40'd1 || qo[0] !== 1'b0) begin
        errors++;
        $display("FAIL ovf_cleared got %h/%0b required 1/0", qd[0], qo[0]);
      end
    end
  endtask

  task automatic test_mid_reset();
    clear_q();
    beat(32'd1000, 1'b0);
    beat(32'd2000, 1'b0);
    beat(32'd3000, 1'b0);
    @(negedge clk);
    idle_drive();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state busy=%0b vld=%0b required 0 0", busy, out_valid);
    end
    beat(32'd9, 1'b1);
    idle();
    wait_results(1);
    repeat (5) @(negedge clk);
    checks++;
    if (qd.size() != 1) begin
      errors++;
      $display("FAIL mid_reset_count got %0d required 1", qd.size());
    end
    if (qd.size() >= 1) begin
      checks++;
      if (qd[0] !== 40'd9 || qo[0] !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_data got %h/%0b required 9/0", qd[0], qo[0]);
      end
    end
  endtask

  task automatic test_update();
    logic          ev;
    logic [AW-1:0] ed;
    clear_q();
    beat(32'd40, 1'b1);
    beat(32'd50, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) idle_drive();
      ev = (k == 3 || k == 4);
      ed = (k == 3) ? 40'd40 : 40'd50;
      checks++;
      if (out_valid !== ev) begin
        errors++;
        $display("FAIL update_valid k=%0d got %0b required %0b", k, out_valid, ev);
      end
      if (ev) begin
        checks++;
        if (out_data !== ed) begin
          errors++;
          $display("FAIL update_data k=%0d got %h required %h", k, out_data, ed);
        end
      end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    stall_waits = 0;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    pp          = '0;
    out_ready   = 1'b1;
    rst_n       = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_mid_reset();
    test_update();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
